// File: rtl/cafe_pkg.sv
// Shared coin codes, coin values and dispenser state encoding for the cafe vend path.
package cafe_pkg;

  typedef enum logic [1:0] {
    CoinNone    = 2'b00,
    CoinNickel  = 2'b01,
    CoinDime    = 2'b10,
    CoinQuarter = 2'b11
  } coin_e;

  localparam logic [4:0] NickelValue  = 5'd5;
  localparam logic [4:0] DimeValue    = 5'd10;
  localparam logic [4:0] QuarterValue = 5'd25;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StVend  = 3'd1,
    StEject = 3'd2,
    StGap   = 3'd3,
    StDone  = 3'd4,
    StFault = 3'd5
  } disp_state_e;

  localparam int unsigned MaxChangeDefault = 20;

  function automatic logic [4:0] coin_value(input coin_e coin);
    logic [4:0] val;
    case (coin)
      CoinNickel:  val = NickelValue;
      CoinDime:    val = DimeValue;
      CoinQuarter: val = QuarterValue;
      default:     val = 5'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/dispense_timer.sv
// Clearable, enabled up-counter; expired_o flags that the count has reached ACK_TIMEOUT.
module dispense_timer #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;

  assign expired_o = (cnt_q == CntW'(ACK_TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Releases the product, then pays change coin by coin through dime/nickel hoppers.
// Optional coin inventory tracking and short-change detection: define CHANGE_INVENTORY_EN.
module change_dispenser
  import cafe_pkg::*;
#(
  parameter int unsigned MAX_CHANGE  = MaxChangeDefault,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned DIME_INIT   = 50,
  parameter int unsigned NICKEL_INIT = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend_in,
  input  logic [4:0] change_in,
  input  logic       hopper_ack,
  output logic       dispense_product,
  output logic       eject_dime,
  output logic       eject_nickel,
  output logic       busy,
  output logic       done,
  output logic       change_err,
  output logic       short_change,
  output logic       fault
);

  disp_state_e state_q;
  coin_e       coin_q;
  coin_e       sel_coin;
  logic [4:0]  remaining_q;
  logic        vend_prev_q;
  logic        dispense_q, eject_dime_q, eject_nickel_q, busy_q, done_q;
  logic        change_err_q, fault_q;
  logic        capture, legal, timer_expired;

  assign capture = vend_in && !vend_prev_q;
  assign legal   = (32'(change_in) <= MAX_CHANGE) && ((change_in % 5'd5) == 5'd0);

  dispense_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    ((state_q != StEject) || hopper_ack),
    .en_i     (state_q == StEject),
    .expired_o(timer_expired)
  );

`ifdef CHANGE_INVENTORY_EN
  logic [7:0] dime_cnt_q, nickel_cnt_q;
  logic       short_q;

  always_comb begin
    sel_coin = CoinNone;
    if (remaining_q >= DimeValue && dime_cnt_q != 8'd0) begin
      sel_coin = CoinDime;
    end else if (remaining_q != 5'd0 && nickel_cnt_q != 8'd0) begin
      sel_coin = CoinNickel;
    end
  end

  assign short_change = short_q;
`else
  // Inventory sizes only matter when coin counters are built.
  logic unused_inv_params;
  assign unused_inv_params = ^{DIME_INIT, NICKEL_INIT};

  always_comb begin
    sel_coin = CoinNone;
    if (remaining_q >= DimeValue) begin
      sel_coin = CoinDime;
    end else if (remaining_q != 5'd0) begin
      sel_coin = CoinNickel;
    end
  end

  assign short_change = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      coin_q         <= CoinNone;
      remaining_q    <= 5'd0;
      vend_prev_q    <= 1'b0;
      dispense_q     <= 1'b0;
      eject_dime_q   <= 1'b0;
      eject_nickel_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      change_err_q   <= 1'b0;
      fault_q        <= 1'b0;
`ifdef CHANGE_INVENTORY_EN
      dime_cnt_q     <= 8'(DIME_INIT);
      nickel_cnt_q   <= 8'(NICKEL_INIT);
      short_q        <= 1'b0;
`endif
    end else begin
      vend_prev_q <= vend_in;
      dispense_q  <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (capture) begin
            state_q      <= StVend;
            dispense_q   <= 1'b1;
            busy_q       <= 1'b1;
            change_err_q <= !legal;
            remaining_q  <= legal ? change_in : 5'd0;
`ifdef CHANGE_INVENTORY_EN
            short_q      <= 1'b0;
`endif
          end
        end
        StVend, StGap: begin
          // With inventory, CoinNone on a nonzero balance means the hoppers ran dry.
          if (remaining_q == 5'd0 || sel_coin == CoinNone) begin
            state_q     <= StDone;
            done_q      <= 1'b1;
            remaining_q <= 5'd0;
`ifdef CHANGE_INVENTORY_EN
            if (remaining_q != 5'd0) short_q <= 1'b1;
`endif
          end else begin
            state_q        <= StEject;
            coin_q         <= sel_coin;
            eject_dime_q   <= (sel_coin == CoinDime);
            eject_nickel_q <= (sel_coin == CoinNickel);
          end
        end
        StEject: begin
          if (hopper_ack) begin
            state_q        <= StGap;
            remaining_q    <= remaining_q - coin_value(coin_q);
            eject_dime_q   <= 1'b0;
            eject_nickel_q <= 1'b0;
`ifdef CHANGE_INVENTORY_EN
            if (coin_q == CoinDime && dime_cnt_q != 8'd0) dime_cnt_q <= dime_cnt_q - 8'd1;
            if (coin_q == CoinNickel && nickel_cnt_q != 8'd0) nickel_cnt_q <= nickel_cnt_q - 8'd1;
`endif
          end else if (timer_expired) begin
            state_q        <= StFault;
            fault_q        <= 1'b1;
            busy_q         <= 1'b0;
            eject_dime_q   <= 1'b0;
            eject_nickel_q <= 1'b0;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        StFault: begin
          state_q <= StFault;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dispense_product = dispense_q;
  assign eject_dime       = eject_dime_q;
  assign eject_nickel     = eject_nickel_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign change_err       = change_err_q;
  assign fault            = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser; a coin-count model predicts each transaction.
`timescale 1ns/1ps
module tb_change_dispenser;

  localparam int unsigned AckTimeout = 255;
`ifdef CHANGE_INVENTORY_EN
  localparam bit          InvEn      = 1'b1;
  localparam int unsigned DimeInit   = 0;
  localparam int unsigned NickelInit = 1;
`else
  localparam bit          InvEn      = 1'b0;
  localparam int unsigned DimeInit   = 50;
  localparam int unsigned NickelInit = 50;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       vend_in;
  logic [4:0] change_in;
  logic       hopper_ack;
  logic       dispense_product, eject_dime, eject_nickel, busy, done;
  logic       change_err, short_change, fault;

  int n_checks = 0;
  int n_fail   = 0;
  int model_dimes, model_nickels;

  always #5 clk = ~clk;

  change_dispenser #(
    .MAX_CHANGE (20),
    .ACK_TIMEOUT(AckTimeout),
    .DIME_INIT  (DimeInit),
    .NICKEL_INIT(NickelInit)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .vend_in         (vend_in),
    .change_in       (change_in),
    .hopper_ack      (hopper_ack),
    .dispense_product(dispense_product),
    .eject_dime      (eject_dime),
    .eject_nickel    (eject_nickel),
    .busy            (busy),
    .done            (done),
    .change_err      (change_err),
    .short_change    (short_change),
    .fault           (fault)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit hit, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; vend_in = 1'b0; hopper_ack = 1'b0; change_in = 5'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_dimes   = DimeInit;
    model_nickels = NickelInit;
  endtask

  task automatic test_reset();
    rst = 1'b1; vend_in = 1'b0; hopper_ack = 1'b0; change_in = 5'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({dispense_product, eject_dime, eject_nickel, busy, done, change_err, short_change, fault}
        !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000000", {dispense_product, eject_dime,
               eject_nickel, busy, done, change_err, short_change, fault});
    end
    rst = 1'b0;
    model_dimes   = DimeInit;
    model_nickels = NickelInit;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, dispense_product} !== 3'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b want 000", {busy, done, dispense_product});
    end
  endtask

  // One full transaction; the model decides coin counts from the change rules alone.
  task automatic run_txn(input logic [4:0] c, input int dly, input bit hold);
    bit   legal, exp_short, acked, got_done, nick_seen;
    int   rem, exp_d, exp_n, got_d, got_n, both_hi, gap_err, order_err, extra_disp;
    int   done_cyc, wait_c, late_disp;
    logic err_at_done, short_at_done;
    legal = (c <= 5'd20) && (c % 5 == 0);
    rem   = legal ? int'(c) : 0;
    exp_d = 0; exp_n = 0; exp_short = 1'b0;
    while (rem > 0) begin
      if (rem >= 10 && (!InvEn || model_dimes > 0)) begin
        exp_d++; rem -= 10; model_dimes--;
      end else if (!InvEn || model_nickels > 0) begin
        exp_n++; rem -= 5; model_nickels--;
      end else begin
        exp_short = 1'b1; rem = 0;
      end
    end
    got_d = 0; got_n = 0; both_hi = 0; gap_err = 0; order_err = 0; extra_disp = 0;
    done_cyc = -1; wait_c = 0; acked = 0; got_done = 0; nick_seen = 0;
    err_at_done = 1'bx; short_at_done = 1'bx;

    @(negedge clk);
    change_in = c; vend_in = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dispense_product !== 1'b1) begin
      n_fail++; $display("FAIL dispense_latency c=%0d: got %b want 1", c, dispense_product);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_in_vend c=%0d: got %b want 1", c, busy);
    end
    if (!hold) vend_in = 1'b0;
    change_in = 5'($urandom_range(0, 31));

    for (int cyc = 0; cyc < 2000 && !got_done; cyc++) begin
      @(negedge clk);
      hopper_ack = 1'b0;
      if (dispense_product) extra_disp++;
      if (eject_dime && eject_nickel) both_hi++;
      if (done) begin
        got_done = 1; done_cyc = cyc; err_at_done = change_err; short_at_done = short_change;
      end else if (acked) begin
        if (eject_dime || eject_nickel) gap_err++;
        acked = 0;
      end else if (eject_dime || eject_nickel) begin
        if (wait_c >= dly) begin
          hopper_ack = 1'b1; acked = 1; wait_c = 0;
          if (eject_dime) begin
            got_d++;
            if (nick_seen) order_err++;
          end else begin
            got_n++; nick_seen = 1;
          end
        end else begin
          wait_c++;
        end
      end
    end
    hopper_ack = 1'b0;

    n_checks++;
    if (!got_done) begin
      n_fail++; $display("FAIL done_seen c=%0d: got no done want done pulse", c);
    end
    n_checks++;
    if (got_d != exp_d) begin
      n_fail++; $display("FAIL dime_count c=%0d: got %0d want %0d", c, got_d, exp_d);
    end
    n_checks++;
    if (got_n != exp_n) begin
      n_fail++; $display("FAIL nickel_count c=%0d: got %0d want %0d", c, got_n, exp_n);
    end
    n_checks++;
    if ({both_hi, gap_err, order_err, extra_disp} != 0) begin
      n_fail++;
      $display("FAIL eject_protocol c=%0d: got both=%0d gap=%0d order=%0d disp=%0d want all 0",
               c, both_hi, gap_err, order_err, extra_disp);
    end
    n_checks++;
    if (err_at_done !== !legal) begin
      n_fail++; $display("FAIL change_err c=%0d: got %b want %b", c, err_at_done, !legal);
    end
    n_checks++;
    if (short_at_done !== exp_short) begin
      n_fail++; $display("FAIL short_change c=%0d: got %b want %b", c, short_at_done, exp_short);
    end
    if (exp_d + exp_n == 0) begin
      n_checks++;
      if (done_cyc != 0) begin
        n_fail++; $display("FAIL zero_change_latency c=%0d: got %0d want 0", c, done_cyc);
      end
    end

    @(negedge clk);
    n_checks++;
    if ({busy, done, change_err} !== {2'b00, !legal}) begin
      n_fail++;
      $display("FAIL after_done c=%0d: got busy,done,err=%b want %b", c, {busy, done, change_err},
               {2'b00, !legal});
    end

    if (hold) begin
      late_disp = 0;
      repeat (6) begin
        @(negedge clk);
        if (dispense_product || busy) late_disp++;
      end
      n_checks++;
      if (late_disp != 0) begin
        n_fail++; $display("FAIL held_vend_retrigger: got %0d active cycles want 0", late_disp);
      end
      vend_in = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_zero_change();
    run_txn(5'd0, 0, 1'b0);
  endtask

  task automatic test_dimes();
    run_txn(5'd20, 3, 1'b0);
  endtask

  task automatic test_mixed_hold();
    run_txn(5'd15, 1, 1'b1);
  endtask

  task automatic test_illegal();
    run_txn(5'd7, 0, 1'b0);
    run_txn(5'd25, 0, 1'b0);
    run_txn(5'd5, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 14; i++) begin
      run_txn(5'($urandom_range(0, 31)), int'($urandom_range(0, 4)), 1'b0);
    end
  endtask

  task automatic test_inventory();
    do_reset();
    run_txn(5'd15, 2, 1'b0);
  endtask

  task automatic test_fault();
    bit exp_dime;
    int bad_disp;
    do_reset();
    exp_dime = !InvEn || (DimeInit > 0);
    @(negedge clk);
    change_in = 5'd10; vend_in = 1'b1;
    @(negedge clk);
    vend_in = 1'b0;
    repeat (AckTimeout - 15) @(negedge clk);
    n_checks++;
    if ({eject_dime, eject_nickel, fault} !== {exp_dime, !exp_dime, 1'b0}) begin
      n_fail++;
      $display("FAIL eject_waiting: got dime,nickel,fault=%b want %b",
               {eject_dime, eject_nickel, fault}, {exp_dime, !exp_dime, 1'b0});
    end
    repeat (40) @(negedge clk);
    n_checks++;
    if ({fault, eject_dime, eject_nickel, busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL timeout_fault: got fault,dime,nickel,busy=%b want 1000",
               {fault, eject_dime, eject_nickel, busy});
    end
    bad_disp = 0;
    for (int i = 0; i < 4; i++) begin
      change_in = 5'd0; vend_in = 1'b1;
      @(negedge clk);
      if (dispense_product || busy || !fault) bad_disp++;
      vend_in = 1'b0;
      @(negedge clk);
      if (dispense_product || busy || !fault) bad_disp++;
    end
    n_checks++;
    if (bad_disp != 0) begin
      n_fail++; $display("FAIL fault_ignores_vend: got %0d bad cycles want 0", bad_disp);
    end
    do_reset();
    n_checks++;
    if (fault !== 1'b0) begin
      n_fail++; $display("FAIL fault_cleared_by_rst: got %b want 0", fault);
    end
  endtask

  task automatic test_reset_mid_eject();
    do_reset();
    @(negedge clk);
    change_in = 5'd20; vend_in = 1'b1;
    @(negedge clk);
    vend_in = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({eject_dime, eject_nickel, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset_eject: got dime,nickel,busy=%b want 000",
               {eject_dime, eject_nickel, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    model_dimes   = DimeInit;
    model_nickels = NickelInit;
    @(negedge clk);
    run_txn(5'd10, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_zero_change();
    test_dimes();
    test_mixed_hold();
    test_illegal();
    test_back_to_back();
    if (InvEn) test_inventory();
    test_fault();
    test_reset_mid_eject();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream stage of the coin-accumulating vend FSM.
- Consumes that FSM's vend strobe (out) and 5-bit change amount in cents, then fires one product-release pulse.
- Pays the change back coin by coin through a dime hopper and a nickel hopper, using a per-coin eject/ack handshake.
- Sits between the vend FSM and the hopper/solenoid drivers.

Parameters:
- MAX_CHANGE, 20, largest legal change_in value in cents.
- ACK_TIMEOUT, 255, cycles an eject may wait for hopper_ack before the block enters FAULT.
- DIME_INIT, 50, dime inventory at reset (used only with CHANGE_INVENTORY_EN).
- NICKEL_INIT, 50, nickel inventory at reset (used only with CHANGE_INVENTORY_EN).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- vend_in  in  1  vend strobe from the vend FSM; level may stay high for many cycles.
- change_in  in  5  change owed in cents; sampled on vend capture.
- hopper_ack  in  1  one-cycle pulse from the hopper: the current coin has dropped.
- dispense_product  out  1  one-cycle product-release pulse.
- eject_dime  out  1  level; held until hopper_ack.
- eject_nickel  out  1  level; held until hopper_ack.
- busy  out  1  high in every state except IDLE and FAULT.
- done  out  1  one-cycle pulse when a transaction completes.
- change_err  out  1  sticky; illegal change_in seen at capture.
- short_change  out  1  sticky; hopper ran dry before change was fully paid.
- fault  out  1  sticky; ack timeout occurred.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE; remaining = 0; the vend_in history flop is 0; the timer is 0.
  - Inventory counters load DIME_INIT and NICKEL_INIT.
- Capture:
  - A capture is a rising edge of vend_in (vend_in=1 while the registered previous value is 0), sampled in IDLE only.
  - Edges while busy or in FAULT are ignored. A held-high vend_in never re-triggers.
  - The capture clears change_err and short_change.
- Validity check:
  - change_in is legal when it is ≤ MAX_CHANGE and change_in % 5 == 0.
  - If legal, remaining = change_in.
  - If illegal, remaining = 0 and change_err = 1.
- States:
  - IDLE: on capture, go to VEND.
  - VEND: dispense_product = 1 for exactly this cycle. Next state is DONE if remaining == 0, else EJECT.
  - EJECT:
    - Coin selection: assert eject_dime if remaining ≥ 10, else assert eject_nickel. Exactly one eject line is high.
    - The timer increments each cycle.
    - On hopper_ack: remaining -= 10 or 5; the timer clears; go to GAP.
    - If the timer reaches ACK_TIMEOUT first, go to FAULT.
  - GAP:
    - One cycle with both eject lines low.
    - Next state is DONE if remaining == 0, else EJECT.
  - DONE: done = 1 for one cycle, then IDLE.
  - FAULT:
    - fault = 1 and all eject lines are low.
    - Only rst exits this state.
- Latency:
  - Capture edge to dispense_product is 1 cycle.
  - Zero-change transaction: done is asserted 2 cycles after capture.
- hopper_ack handling:
  - Ignored outside EJECT.
  - An ack in the same cycle the timer hits ACK_TIMEOUT counts as success.
- Arithmetic: remaining is 5 bits, unsigned. It never underflows, because the coin value selected is always ≤ remaining.
- Reset mid-transaction: eject lines drop immediately (asynchronously), and the coin in flight is not counted.

Optional Feature:
CHANGE_INVENTORY_EN
- Defined:
  - 8-bit dime_cnt and nickel_cnt each decrement on the hopper_ack of their coin type, saturating at 0.
  - Selection: use a dime when remaining ≥ 10 and dime_cnt > 0; otherwise use a nickel when nickel_cnt > 0.
  - If no coin is usable while remaining > 0: short_change = 1, then go straight to DONE with the unpaid balance dropped.
- Undefined:
  - No counters are built.
  - short_change is tied to 0.
  - Coin selection uses remaining only.

Decomposition:
- Package cafe_pkg holds:
  - the coin codes: NONE=2'b00, NICKEL=2'b01, DIME=2'b10, QUARTER=2'b11;
  - the coin values 5, 10 and 25;
  - the dispenser state encoding (IDLE, VEND, EJECT, GAP, DONE, FAULT);
  - the default of MAX_CHANGE.
- One natural sub-module, dispense_timer: a clearable, enabled counter with a terminal flag at ACK_TIMEOUT.

Test Plan:
- Reset, then vend rising edge with change_in=0 → dispense_product pulses 1 cycle later, done 2 cycles after capture, no eject lines ever high.
- change_in=20, hopper_ack 3 cycles after each eject → eject_dime, GAP, eject_dime, GAP, done. Exactly 2 dime ejects and zero nickel ejects.
- change_in=15 → one eject_dime followed by one eject_nickel, then done. vend_in held high throughout causes no second transaction.
- change_in=7, and separately change_in=25 → change_err=1, product is still dispensed, no ejects, done pulses. change_err clears on the next valid capture.
- change_in=10 with no ack for 255 cycles → fault=1, eject_dime drops, busy=0, new vend edges ignored until rst.
- With CHANGE_INVENTORY_EN and DIME_INIT=0, NICKEL_INIT=1, change_in=15 → one eject_nickel, then short_change=1 and done.
